// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite transfer encodings and interconnect arbiter state type
// Provides HTRANS/HBURST codes, the arbiter FSM enum and the fixed-burst beat helper.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0, HBURST_INCR = 3'd1, HBURST_WRAP4 = 3'd2, HBURST_INCR4 = 3'd3,
                         HBURST_WRAP8 = 3'd4, HBURST_INCR8 = 3'd5, HBURST_WRAP16 = 3'd6, HBURST_INCR16 = 3'd7;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_BURST = 2'd1, ARB_INCR = 2'd2, ARB_LOCKED = 2'd3} arb_state_t;
  // beats remaining after the NONSEQ of a fixed-length burst; WRAPn/INCRn share hburst[2:1]
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    return hburst[2:1] == 2'b01 ? 4'd3 : hburst[2:1] == 2'b10 ? 4'd7 : hburst[2:1] == 2'b11 ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/ahb3lite_interconnect_slave_priority.sv
// ahb3lite_interconnect_slave_priority: highest priority level among requesting masters
// Ports: req (per-master request), prio (per-master priority), max_prio (highest requested level, 0 if none).
module ahb3lite_interconnect_slave_priority #(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0]     req,
  input  logic [MASTER_BITS-1:0] prio [MASTERS],
  output logic [MASTER_BITS-1:0] max_prio
);
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < MASTERS; i++) max_prio = req[i] && prio[i] > max_prio ? prio[i] : max_prio;
  end
endmodule

// File: rtl/ahb3lite_interconnect_arbiter.sv
// ahb3lite_interconnect_arbiter: priority/round-robin AHB3-Lite slave-port arbiter with burst and lock awareness
// Ports: HCLK/HRESET (sync, active-high), HREADY (advances all state), per-master mstHSEL/mstpriority/
// mstHTRANS/mstHBURST/mstHMASTLOCK; granted_master (one-hot), granted_master_idx (address phase),
// granted_master_idx_dly (data phase), can_switch (combinational), arb_state (debug).
module ahb3lite_interconnect_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  parameter int HOLD_MAX    = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HREADY,
  input  logic [MASTERS-1:0]     mstHSEL,
  input  logic [MASTER_BITS-1:0] mstpriority [MASTERS],
  input  logic [1:0]             mstHTRANS [MASTERS],
  input  logic [2:0]             mstHBURST [MASTERS],
  input  logic [MASTERS-1:0]     mstHMASTLOCK,
  output logic [MASTERS-1:0]     granted_master,
  output logic [MASTER_BITS-1:0] granted_master_idx,
  output logic [MASTER_BITS-1:0] granted_master_idx_dly,
  output logic                   can_switch,
  output logic [1:0]             arb_state
);
  localparam int LEVELS = 2 ** MASTER_BITS;
  localparam int HB = $clog2(HOLD_MAX + 1);
  arb_state_t state, state_nxt;
  logic [3:0] beats, beats_nxt;
  logic [HB-1:0] hold, hold_nxt;
  logic [MASTER_BITS-1:0] ptr [LEVELS];
  logic [MASTER_BITS-1:0] gm, max_prio, winner, c;
  logic [1:0] trans;
  logic [2:0] burst;
  logic sel, lock, others, any_req;
  assign gm = granted_master_idx;
  assign sel = mstHSEL[gm];
  assign lock = mstHMASTLOCK[gm];
  assign trans = mstHTRANS[gm];
  assign burst = mstHBURST[gm];
  assign others = |(mstHSEL & ~granted_master);
  assign arb_state = state;
  ahb3lite_interconnect_slave_priority #(.MASTERS(MASTERS), .MASTER_BITS(MASTER_BITS)) u_prio (
    .req(mstHSEL), .prio(mstpriority), .max_prio(max_prio)
  );
  // round-robin within the winning level, starting just after that level's last grant
  always_comb begin
    winner = gm;
    any_req = 1'b0;
    c = ptr[max_prio];
    for (int k = 0; k < MASTERS; k++) begin
      c = c == MASTER_BITS'(MASTERS - 1) ? '0 : c + 1'b1;
      if (!any_req && mstHSEL[c] && mstpriority[c] == max_prio) begin
        winner = c;
        any_req = 1'b1;
      end
    end
  end
  assign can_switch = !sel ? 1'b1 :
                      state == ARB_LOCKED ? 1'b0 :
                      state == ARB_IDLE ? 1'b1 :
                      state == ARB_BURST ? beats == '0 :
                      trans == HTRANS_IDLE || trans == HTRANS_NONSEQ || (hold == HB'(HOLD_MAX) && others);
  // lock evaluation first, then burst tracking; a grant change always restarts from IDLE
  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    hold_nxt = hold;
    if (lock && trans != HTRANS_IDLE) state_nxt = ARB_LOCKED;
    else if (state == ARB_LOCKED) state_nxt = lock ? ARB_LOCKED : ARB_IDLE;
    else if (trans == HTRANS_NONSEQ) begin
      beats_nxt = burst_beats(burst);
      hold_nxt = '0;
      state_nxt = burst == HBURST_SINGLE ? ARB_IDLE : burst == HBURST_INCR ? ARB_INCR : ARB_BURST;
    end else if (state == ARB_BURST) begin
      beats_nxt = trans == HTRANS_SEQ && beats != '0 ? beats - 4'd1 : beats;
      state_nxt = trans == HTRANS_IDLE || beats == '0 ? ARB_IDLE : ARB_BURST;
    end else if (state == ARB_INCR) begin
      hold_nxt = trans == HTRANS_SEQ && hold != HB'(HOLD_MAX) ? hold + 1'b1 : hold;
      state_nxt = trans == HTRANS_IDLE ? ARB_IDLE : ARB_INCR;
    end
    if (can_switch && winner != gm) state_nxt = ARB_IDLE;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ARB_IDLE;
      beats <= '0;
      hold <= '0;
      granted_master <= MASTERS'(1);
      granted_master_idx <= '0;
      granted_master_idx_dly <= '0;
      for (int i = 0; i < LEVELS; i++) ptr[i] <= '0;
    end else if (HREADY) begin
      state <= state_nxt;
      beats <= beats_nxt;
      hold <= hold_nxt;
      granted_master_idx_dly <= granted_master_idx;
      if (can_switch && any_req) begin
        granted_master <= MASTERS'(1) << winner;
        granted_master_idx <= winner;
        ptr[max_prio] <= winner;
      end
    end
  end
endmodule

// File: tb/tb_ahb3lite_interconnect_arbiter.sv
// tb_ahb3lite_interconnect_arbiter: cycle-vector bench with a post-edge scoreboard for the arbiter
module tb_ahb3lite_interconnect_arbiter;
  import ahb3lite_pkg::*;
  localparam logic [1:0] I = HTRANS_IDLE, B = HTRANS_BUSY, N = HTRANS_NONSEQ, S = HTRANS_SEQ;
  localparam logic [5:0] P0 = 6'd0, PH = {2'd0, 2'd2, 2'd1};
  // inputs for one cycle, expected can_switch during it, expected registered outputs after its edge
  typedef struct packed {
    logic rst, rdy;
    logic [2:0] sel;
    logic [5:0] trans;
    logic [8:0] burst;
    logic [2:0] lock;
    logic [5:0] prio;
    logic cs;
    logic [1:0] idx, dly, st;
  } vec_t;
  typedef struct packed {
    logic [1:0] idx, dly, st;
    int n;
  } exp_t;
  logic clk = 1'b0, rst, rdy, cs;
  logic [2:0] sel, lock, gnt;
  logic [1:0] prio [3];
  logic [1:0] trans [3];
  logic [2:0] burst [3];
  logic [1:0] idx, dly, st;
  int n_vec = 0, n_err = 0;
  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  ahb3lite_interconnect_arbiter #(.MASTERS(3), .HOLD_MAX(4)) dut (
    .HCLK(clk), .HRESET(rst), .HREADY(rdy), .mstHSEL(sel), .mstpriority(prio), .mstHTRANS(trans),
    .mstHBURST(burst), .mstHMASTLOCK(lock), .granted_master(gnt), .granted_master_idx(idx),
    .granted_master_idx_dly(dly), .can_switch(cs), .arb_state(st)
  );
  task automatic chk(input string nm, input int n, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h, expected %0h", nm, n, act, exp);
    end
  endtask
  function automatic void add(input logic r, input logic y, input logic [2:0] s, input logic [5:0] t,
                              input logic [8:0] b, input logic [2:0] l, input logic [5:0] p,
                              input logic c, input logic [1:0] gi, input logic [1:0] gd, input logic [1:0] q);
    vecs.push_back('{rst: r, rdy: y, sel: s, trans: t, burst: b, lock: l, prio: p, cs: c, idx: gi, dly: gd, st: q});
  endfunction
  task automatic apply(input vec_t x, input int n);
    @(negedge clk);
    rst = x.rst;
    rdy = x.rdy;
    sel = x.sel;
    lock = x.lock;
    for (int m = 0; m < 3; m++) begin
      prio[m] = x.prio[2*m +: 2];
      trans[m] = x.trans[2*m +: 2];
      burst[m] = x.burst[3*m +: 3];
    end
    #1 chk("can_switch", n, 4'(cs), 4'(x.cs));
    sb.push_back('{idx: x.idx, dly: x.dly, st: x.st, n: n});
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("granted_master_idx", e.n, 4'(idx), 4'(e.idx));
      chk("granted_master_idx_dly", e.n, 4'(dly), 4'(e.dly));
      chk("arb_state", e.n, 4'(st), 4'(e.st));
      chk("granted_master", e.n, 4'(gnt), 4'(3'b001 << e.idx));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d vectors pending", sb.size());
    $fatal(1);
  end
  initial begin
    // equal-priority single transfers from m1 and m2 alternate; dly trails by one beat
    add(0, 1, 3'b110, {N, N, I}, 9'o000, 3'b000, P0, 1, 1, 0, 0);
    add(0, 1, 3'b110, {N, N, I}, 9'o000, 3'b000, P0, 1, 2, 1, 0);
    add(0, 1, 3'b110, {N, N, I}, 9'o000, 3'b000, P0, 1, 1, 2, 0);
    add(0, 1, 3'b110, {N, N, I}, 9'o000, 3'b000, P0, 1, 2, 1, 0);
    add(0, 1, 3'b000, {I, I, I}, 9'o000, 3'b000, P0, 1, 2, 2, 0);
    // m0 INCR8 with m2 waiting from beat 2, one BUSY and one stall inside
    add(0, 1, 3'b001, {I, I, I}, 9'o000, 3'b000, P0, 1, 0, 2, 0);
    add(0, 1, 3'b001, {I, I, N}, 9'o005, 3'b000, P0, 1, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, B}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 0, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, S}, 9'o005, 3'b000, P0, 0, 0, 0, 1);
    add(0, 1, 3'b101, {I, I, I}, 9'o005, 3'b000, P0, 1, 2, 0, 0);
    // m1 at priority 2 beats m0 at priority 1 until it drops its request
    add(0, 1, 3'b011, {I, I, I}, 9'o000, 3'b000, PH, 1, 1, 2, 0);
    add(0, 1, 3'b011, {I, I, I}, 9'o000, 3'b000, PH, 1, 1, 1, 0);
    add(0, 1, 3'b011, {I, I, I}, 9'o000, 3'b000, PH, 1, 1, 1, 0);
    add(0, 1, 3'b001, {I, I, I}, 9'o000, 3'b000, PH, 1, 0, 1, 0);
    add(0, 1, 3'b001, {I, I, I}, 9'o000, 3'b000, PH, 1, 0, 0, 0);
    // m0 locked INCR4 then IDLE with lock held; m1 only wins after the lock drops
    add(0, 1, 3'b001, {I, I, N}, 9'o003, 3'b001, P0, 1, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, S}, 9'o003, 3'b001, P0, 0, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, S}, 9'o003, 3'b001, P0, 0, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, S}, 9'o003, 3'b001, P0, 0, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, I}, 9'o003, 3'b001, P0, 0, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, I}, 9'o003, 3'b001, P0, 0, 0, 0, 3);
    add(0, 1, 3'b011, {I, I, I}, 9'o000, 3'b000, P0, 0, 0, 0, 0);
    add(0, 1, 3'b011, {I, I, I}, 9'o000, 3'b000, P0, 1, 1, 0, 0);
    // undefined INCR from m0 with m1 waiting: switch once 4 SEQs accepted, stalls do not count
    add(0, 1, 3'b001, {I, I, I}, 9'o000, 3'b000, P0, 1, 0, 1, 0);
    add(0, 1, 3'b001, {I, I, N}, 9'o001, 3'b000, P0, 1, 0, 0, 2);
    add(0, 1, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 0, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 1, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 0, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 1, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 1, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 0, 0, 0, 2);
    add(0, 1, 3'b011, {I, I, S}, 9'o001, 3'b000, P0, 1, 1, 0, 0);
    // reset in the middle of an m1 WRAP8
    add(0, 1, 3'b010, {I, N, I}, 9'o040, 3'b000, P0, 1, 1, 1, 1);
    add(0, 1, 3'b010, {I, S, I}, 9'o040, 3'b000, P0, 0, 1, 1, 1);
    add(0, 1, 3'b010, {I, S, I}, 9'o040, 3'b000, P0, 0, 1, 1, 1);
    add(1, 1, 3'b010, {I, S, I}, 9'o040, 3'b000, P0, 0, 0, 0, 0);
    add(0, 1, 3'b010, {I, S, I}, 9'o040, 3'b000, P0, 1, 1, 0, 0);
    // early termination: NONSEQ reloads a new burst, then a SINGLE ends it
    add(0, 1, 3'b010, {I, N, I}, 9'o030, 3'b000, P0, 1, 1, 1, 1);
    add(0, 1, 3'b010, {I, S, I}, 9'o030, 3'b000, P0, 0, 1, 1, 1);
    add(0, 1, 3'b010, {I, N, I}, 9'o020, 3'b000, P0, 0, 1, 1, 1);
    add(0, 1, 3'b010, {I, N, I}, 9'o000, 3'b000, P0, 0, 1, 1, 0);
    rst = 1'b1;
    rdy = 1'b1;
    sel = '0;
    lock = '0;
    for (int m = 0; m < 3; m++) begin
      prio[m] = '0;
      trans[m] = I;
      burst[m] = HBURST_SINGLE;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("reset granted_master", -1, 4'(gnt), 4'b0001);
    chk("reset idx", -1, 4'(idx), 4'd0);
    chk("reset dly", -1, 4'(dly), 4'd0);
    chk("reset state", -1, 4'(st), 4'(ARB_IDLE));
    chk("reset can_switch", -1, 4'(cs), 4'd1);
    foreach (vecs[n]) apply(vecs[n], n);
    // reset wins over a stalled bus, then the grant stays frozen until HREADY returns
    apply('{rst: 1, rdy: 0, sel: 3'b010, trans: {I, I, I}, burst: 9'o000, lock: 3'b000, prio: P0, cs: 1, idx: 0, dly: 0, st: 0}, 100);
    apply('{rst: 0, rdy: 0, sel: 3'b010, trans: {I, I, I}, burst: 9'o000, lock: 3'b000, prio: P0, cs: 1, idx: 0, dly: 0, st: 0}, 101);
    apply('{rst: 0, rdy: 1, sel: 3'b010, trans: {I, I, I}, burst: 9'o000, lock: 3'b000, prio: P0, cs: 1, idx: 1, dly: 0, st: 0}, 102);
    repeat (2) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
